// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction
// memory and registers each word toward decode under a valid/ready handshake.
module fetch_ctrl #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0]  PC_LAST  = 8'h3A
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic              xfer;
  logic              capture;
  logic              target_ok;
  logic              is_halt;

  assign im_addr   = pc;
  assign xfer      = instr_valid && instr_ready;
  assign capture   = (state == S_RUN) && !redirect && (!instr_valid || instr_ready);
  assign target_ok = !redirect_addr[0] && (redirect_addr <= PC_LAST);
  assign is_halt   = (im_instr[INSTR_W-1 -: 4] == 4'hE);
  // The IM ends at PC_LAST, so sequential fetch wraps back to address zero there.
  assign pc_seq    = (pc == PC_LAST) ? '0 : pc + ADDR_W'(2);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of pc, state and instr_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_RUN;
        end
        S_RUN, S_DRAIN: begin
          // A redirect flushes whatever is held; a drain is on the wrong path then.
          if (redirect) begin
            instr_valid <= 1'b0;
            if (target_ok) begin
              pc    <= redirect_addr;
              state <= S_RUN;
            end else begin
              fault <= 1'b1;
              state <= S_FAULT;
            end
          end else if (capture) begin
            instr_out   <= im_instr;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_seq;
            if (is_halt) state <= S_DRAIN;
          end else if (state == S_DRAIN && instr_ready) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= S_HALT;
          end
        end
        S_HALT, S_FAULT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transfers also count on a redirect edge; the flush only affects the next word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (xfer && fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [7:0] PC_LAST = 8'h3A;

  logic        clk = 1'b0;
  logic        reset, start, instr_ready, redirect;
  logic [7:0]  redirect_addr;
  logic [7:0]  im_addr, pc_out;
  logic [15:0] im_instr, instr_out, fetch_count;
  logic        instr_valid, halted, fault;

  logic [15:0] im_mem [0:127];
  logic [15:0] prog   [0:29] = '{
    16'hF120, 16'hF121, 16'h93FF, 16'h834C, 16'h1234, 16'h2345, 16'h3456, 16'h4567,
    16'h5678, 16'h6789, 16'h789A, 16'h89AB, 16'h9ABC, 16'h6704, 16'hFB10, 16'hABCD,
    16'hBCDE, 16'hCDEF, 16'hD00D, 16'h0F0F, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
    16'h5555, 16'h6666, 16'h7777, 16'hEFFF, 16'h0001, 16'hF110};

  int errors = 0;
  int checks = 0;

  typedef enum {M_IDLE, M_FETCH, M_DRAIN, M_DONE, M_DEAD} mphase_t;
  mphase_t     m_phase;
  int          m_pc, m_pcout, m_count;
  bit          m_valid, m_halted, m_fault;
  logic [15:0] m_instr;

  always #5 clk = ~clk;

  assign im_instr = im_mem[im_addr[7:1]];

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .im_addr(im_addr), .im_instr(im_instr),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what one clock edge does, given the inputs presented before it.
  task automatic model_edge();
    logic [15:0] w;
    if (!reset) begin
      m_phase = M_IDLE; m_pc = 0; m_pcout = 0; m_count = 0;
      m_valid = 0; m_halted = 0; m_fault = 0; m_instr = '0;
      return;
    end
    case (m_phase)
      M_IDLE: if (start) m_phase = M_FETCH;
      M_FETCH, M_DRAIN: begin
        if (m_valid && instr_ready && m_count < 65535) m_count++;
        if (redirect) begin
          m_valid = 0;
          if (redirect_addr % 2 == 0 && redirect_addr <= PC_LAST) begin
            m_pc = redirect_addr;
            m_phase = M_FETCH;
          end else begin
            m_fault = 1;
            m_phase = M_DEAD;
          end
        end else if (m_phase == M_FETCH) begin
          if (!m_valid || instr_ready) begin
            w       = im_mem[m_pc / 2];
            m_instr = w;
            m_pcout = m_pc;
            m_valid = 1;
            m_pc    = (m_pc == PC_LAST) ? 0 : (m_pc + 2) % 256;
            if (w[15:12] == 4'hE) m_phase = M_DRAIN;
          end
        end else if (instr_ready) begin
          m_valid  = 0;
          m_halted = 1;
          m_phase  = M_DONE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("valid",   32'(instr_valid), 32'(m_valid));
    check("instr",   32'(instr_out),   32'(m_instr));
    check("pc_out",  32'(pc_out),      m_pcout);
    check("im_addr", 32'(im_addr),     m_pc);
    check("halted",  32'(halted),      32'(m_halted));
    check("fault",   32'(fault),       32'(m_fault));
    check("count",   32'(fetch_count), m_count);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; redirect = 1'b0; redirect_addr = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w, input logic [7:0] a);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(instr_out), 32'(w));
    check({tag, "_pc"},    32'(pc_out), 32'(a));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) im_mem[i] = (i < 30) ? prog[i] : 16'h0000;
    instr_ready = 1'b1;
    do_reset();
    check("rst_addr", 32'(im_addr), 32'h00);
    check("rst_cnt",  32'(fetch_count), 32'h0);

    // Standard program, decode always ready.
    start = 1'b1; step(); start = 1'b0;
    step(); expect_word("first", 16'hF120, 8'h00);
    step(); expect_word("second", 16'hF121, 8'h02);
    repeat (26) step();
    expect_word("haltw", 16'hEFFF, 8'h36);
    step();
    check("std_halted", 32'(halted), 32'd1);
    check("std_valid",  32'(instr_valid), 32'd0);
    check("std_count",  32'(fetch_count), 32'h1C);
    repeat (3) step();
    check("halt_hold", 32'(halted), 32'd1);

    // Backpressure while 93FF@04 is presented.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    expect_word("pre_stall", 16'h93FF, 8'h04);
    instr_ready = 1'b0;
    repeat (3) begin
      step();
      expect_word("stall", 16'h93FF, 8'h04);
      check("stall_addr", 32'(im_addr), 32'h06);
    end
    instr_ready = 1'b1;
    step(); expect_word("post_stall", 16'h834C, 8'h06);

    // Legal redirect: one bubble, then the target stream.
    redirect = 1'b1; redirect_addr = 8'h1A; step(); redirect = 1'b0;
    check("redir_bubble", 32'(instr_valid), 32'd0);
    step(); expect_word("redir_t0", 16'h6704, 8'h1A);
    step(); expect_word("redir_t1", 16'hFB10, 8'h1C);

    // Redirect to the last legal address, then sequential wrap.
    redirect = 1'b1; redirect_addr = 8'h3A; step(); redirect = 1'b0;
    step(); expect_word("wrap_last", 16'hF110, 8'h3A);
    step(); expect_word("wrap_zero", 16'hF120, 8'h00);

    // Illegal (odd) target faults; start and redirect are then ignored.
    redirect = 1'b1; redirect_addr = 8'h3B; step(); redirect = 1'b0;
    check("fault_set",   32'(fault), 32'd1);
    check("fault_valid", 32'(instr_valid), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    redirect = 1'b1; redirect_addr = 8'h10; step(); redirect = 1'b0;
    check("fault_stay", 32'(fault), 32'd1);
    check("fault_addr", 32'(im_addr), 32'h02);

    // Reset in the middle of a run with ready toggling.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      instr_ready = i[0];
      step();
    end
    reset = 1'b0; step(); reset = 1'b1;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_addr",  32'(im_addr), 32'h00);
    check("mid_rst_count", 32'(fetch_count), 32'h0);
    instr_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); expect_word("resume", 16'hF120, 8'h00);

    // Random traffic over a random memory image.
    for (int i = 0; i < 30; i++) im_mem[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 59) != 0);
      start         = ($urandom_range(0, 3) == 0);
      instr_ready   = ($urandom_range(0, 99) < 65);
      redirect      = ($urandom_range(0, 15) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'(2 * $urandom_range(0, 29));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the 16-bit instruction memory (`IM`) and the decode stage. It owns the program counter and drives `IM`'s byte address, which steps by 2. It registers each fetched word toward decode under a valid/ready handshake and accepts branch redirects. It stops on a halt opcode (`[15:12] == 4'hE`) or on an illegal redirect target.

## Interface
Parameters:
- `ADDR_W`, 8, PC / IM address width
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 8'h00, PC value after reset
- `PC_LAST`, 8'h3A, highest legal fetch address (60-byte IM)

Ports:
- `clk`  in  1  system clock, all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin fetching; sampled only in IDLE
- `im_addr`  out  ADDR_W  address to `IM.addr_in`; equals the PC register
- `im_instr`  in  INSTR_W  `IM.instruc_out`, combinational from `im_addr`
- `instr_out`  out  INSTR_W  registered instruction to decode
- `pc_out`  out  ADDR_W  address of `instr_out`
- `instr_valid`  out  1  `instr_out`/`pc_out` hold a live instruction
- `instr_ready`  in  1  decode accepts when high with `instr_valid`
- `redirect`  in  1  branch/jump taken, one-cycle pulse
- `redirect_addr`  in  ADDR_W  new PC target
- `halted`  out  1  halt instruction delivered and accepted
- `fault`  out  1  illegal redirect target seen
- `fetch_count`  out  16  accepted-instruction count, saturating

## Operation
- Reset (`reset==0` at an edge):
  - `pc = RESET_PC`; all outputs 0 (`im_addr = RESET_PC`).
  - State IDLE.
- States:
  - IDLE: `start==1` -> RUN. All other inputs are ignored.
  - RUN: a capture occurs when `!instr_valid || instr_ready` and there is no redirect. On capture: `instr_out <= im_instr`, `pc_out <= pc`, `instr_valid <= 1`, `pc <= pc + 2`. If the captured word has `[15:12] == 4'hE` -> DRAIN (the halt word is still delivered).
  - DRAIN: no further captures. `pc` is frozen. When `instr_ready` is high: `instr_valid <= 0`, `halted <= 1` -> HALT.
  - HALT: terminal. `halted=1`, `instr_valid=0`. Exit only via reset.
  - FAULT: terminal. `fault=1`, `instr_valid=0`. Exit only via reset.
- Handshake: a transfer happens on an edge where `instr_valid && instr_ready`. Without a transfer, `instr_out` and `pc_out` stay stable while `instr_valid` is high.
- Redirect is honored in RUN and DRAIN and ignored in IDLE, HALT and FAULT. It has priority over capture.
  - Legal target: even and `<= PC_LAST`. Effect: `instr_valid <= 0` (flush), `pc <= redirect_addr`, state becomes RUN. A DRAIN is cancelled, because the halt was on the wrong path.
  - Illegal target (odd or `> PC_LAST`): `instr_valid <= 0`, `pc` unchanged, `fault <= 1` -> FAULT.
- Wrap-around: a sequential increment from `PC_LAST` gives `pc <= 8'h00`. Arithmetic is mod 2^ADDR_W otherwise.
- `fetch_count` increments on every transfer, including the halt word. It saturates at 16'hFFFF.
- Simultaneous events:
  - `redirect` and a transfer on the same edge: the transfer counts, then the flush happens.
  - `start` outside IDLE has no effect.

## Timing
- Start latency: `start` is sampled at edge E0 (state RUN). The first capture is at E1, so `instr_valid=1` after E1.
- Throughput: one instruction per cycle while `instr_ready` is held high.
- Redirect penalty: `redirect` is sampled at edge En. `instr_valid=0` after En. The target instruction is valid after En+1, which is one bubble.
- Backpressure:
  - `pc` and `im_addr` hold whenever a capture is blocked.
  - `IM` is combinational and read in the same cycle, so no extra stall is needed.
- Halt: `halted` rises on the same edge that `instr_valid` falls after the halt word is accepted.
- Reset mid-operation: it takes effect at the next edge regardless of state or handshake.
- There are no combinational paths from inputs to outputs. All outputs are registered except `im_addr`, which is the PC register.

## Test plan
- Reset, then `start` with `instr_ready=1` and the standard program → sequence F120@00, F121@02, 93FF@04, 834C@06, ... EFFF@36. Required result: `halted=1`, `instr_valid=0`, `fetch_count=16'h001C`.
- `instr_ready=0` for 3 cycles while 93FF@04 is valid → `instr_out=93FF`, `pc_out=04` and `im_addr=06` all stable. 834C@06 follows on the cycle after ready rises.
- `redirect=1`, `redirect_addr=8'h1A` during RUN → `instr_valid=0` for one cycle, then 6704@1A, then FB10@1C.
- `redirect_addr=8'h3B` → `fault=1`, `instr_valid=0`. A later `start` or `redirect` is ignored until reset.
- Bench IM with F110 at 3A; redirect to 3A → F110@3A, then F120@00 (wrap).
- Reset asserted mid-run with `instr_ready` toggling → next edge all outputs 0 and state IDLE. After `start`, fetching resumes with F120@00.
